// File: rtl/raycast_pkg.sv
// Shared types for the octree raycast traversal: controller state encoding
// and the 3-bit child index carried between the sequencer and the index unit.
package raycast_pkg;

    typedef logic [2:0] idx_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FIRST = 3'd1,
        ST_FETCH = 3'd2,
        ST_PLANE = 3'd3,
        ST_STEP  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [15:0] STEP_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/raycast_idx_stack.sv
// Per-level child-index stack: one synchronous write port and an
// asynchronous read, both addressed by the current level.
module raycast_idx_stack
    import raycast_pkg::*;
#(
    parameter int max_lvl = 8,
    parameter int lw      = 3
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          we_i,
    input  logic [lw-1:0] lvl_i,
    input  idx_t          wdata_i,
    output idx_t          rdata_o
);

    idx_t mem [max_lvl];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < max_lvl; i++) begin
                mem[i] <= '0;
            end
        end else if (we_i) begin
            mem[lvl_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[lvl_i];

endmodule

// File: rtl/raycast_core_trav.sv
// Traversal sequencer: walks one ray through the sparse voxel octree by
// sequencing the index unit, node fetch and exit-plane requests.
//
// Handshakes: node_req_o / plane_req_o are level requests held high from the
// first cycle of FETCH / PLANE until the matching ack is sampled high; an ack
// may arrive in the first request cycle, and acks outside the request state
// are ignored. abort_i overrides every transition and never produces done_o.
module raycast_core_trav
    import raycast_pkg::*;
#(
    parameter int dw      = 32,
    parameter int max_lvl = 8,
    parameter int lw      = 3
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          start_i,
    input  logic          abort_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          hit_o,
    output logic [lw-1:0] lvl_o,
    output logic          is_first_o,
    output idx_t          idx_o,
    input  idx_t          idx_next_i,
    input  logic          is_exit_i,
    output logic          node_req_o,
    input  logic          node_ack_i,
    input  logic          node_valid_i,
    input  logic          node_leaf_i,
    output logic          plane_req_o,
    input  logic          plane_ack_i,
    output logic [15:0]   step_cnt_o,
    output logic [2:0]    state_o
);

    if (lw < $clog2(max_lvl) || dw < 1) begin : g_param_check
        $error("raycast_core_trav: lw too narrow for max_lvl or dw invalid");
    end

    state_t        state_q, state_d;
    logic [lw-1:0] lvl_q;
    logic          hit_q;
    logic [15:0]   cnt_q;

    logic at_bottom, fetch_ack, leaf_hit, push, step_ev, pop, root_exit;
    logic start_ok, stack_we;

    assign at_bottom = (lvl_q == lw'(max_lvl - 1));
    assign start_ok  = (state_q == ST_IDLE) && start_i && !abort_i;
    assign fetch_ack = (state_q == ST_FETCH) && node_ack_i && !abort_i;
    assign leaf_hit  = fetch_ack && node_valid_i && (node_leaf_i || at_bottom);
    assign push      = fetch_ack && node_valid_i && !node_leaf_i && !at_bottom;
    assign step_ev   = (state_q == ST_STEP) && !abort_i;
    assign pop       = step_ev && is_exit_i && (lvl_q != '0);
    assign root_exit = step_ev && is_exit_i && (lvl_q == '0);
    assign stack_we  = !abort_i &&
                       ((state_q == ST_FIRST) || ((state_q == ST_STEP) && !is_exit_i));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_FIRST;
            ST_FIRST: state_d = ST_FETCH;
            ST_FETCH: begin
                if (node_ack_i) begin
                    if (node_valid_i && (node_leaf_i || at_bottom)) state_d = ST_DONE;
                    else if (node_valid_i)                          state_d = ST_FIRST;
                    else                                            state_d = ST_PLANE;
                end
            end
            ST_PLANE: if (plane_ack_i) state_d = ST_STEP;
            ST_STEP: begin
                if (!is_exit_i)        state_d = ST_FETCH;
                else if (lvl_q != '0)  state_d = ST_PLANE;
                else                   state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort_i) state_d = ST_IDLE;
    end

    always_comb begin
        busy_o      = (state_q != ST_IDLE);
        done_o      = (state_q == ST_DONE);
        is_first_o  = (state_q == ST_FIRST);
        node_req_o  = (state_q == ST_FETCH);
        plane_req_o = (state_q == ST_PLANE);
    end

    // Level, result and fetch counter; abort freezes everything but the result.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lvl_q <= '0;
            hit_q <= 1'b0;
            cnt_q <= '0;
        end else if (abort_i) begin
            hit_q <= 1'b0;
        end else begin
            if (start_ok) begin
                lvl_q <= '0;
                hit_q <= 1'b0;
                cnt_q <= '0;
            end
            if (push) lvl_q <= lvl_q + lw'(1);
            if (pop)  lvl_q <= lvl_q - lw'(1);
            if (fetch_ack && (cnt_q != STEP_CNT_MAX)) cnt_q <= cnt_q + 16'd1;
            if (leaf_hit)  hit_q <= 1'b1;
            if (root_exit) hit_q <= 1'b0;
        end
    end

    raycast_idx_stack #(
        .max_lvl (max_lvl),
        .lw      (lw)
    ) u_stack (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .we_i    (stack_we),
        .lvl_i   (lvl_q),
        .wdata_i (idx_next_i),
        .rdata_o (idx_o)
    );

    assign hit_o      = hit_q;
    assign lvl_o      = lvl_q;
    assign step_cnt_o = cnt_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_raycast_core_trav.sv
// Bench for raycast_core_trav: table-driven index unit and node memory, an
// algorithmic traversal model feeding expected queues, per-cycle comparison.
module tb_raycast_core_trav;
  localparam int MAX = 8;

  logic clk = 0;
  logic rst_n_i, start_i, abort_i;
  logic busy_o, done_o, hit_o, is_first_o, is_exit_i;
  logic [2:0] lvl_o, idx_o, idx_next_i, state_o;
  logic node_req_o, node_ack_i, node_valid_i, node_leaf_i;
  logic plane_req_o, plane_ack_i;
  logic [15:0] step_cnt_o;

  // scenario tables: node memory keyed by (lvl, idx) and an index-unit model
  bit vtab [MAX][8];
  bit ltab [MAX][8];
  logic [2:0] first_tab [MAX];
  logic [2:0] nxt_tab [8];
  bit ext_tab [8];

  logic [5:0] fetch_q[$];
  logic [5:0] plane_q[$];
  int exp_cnt, exp_lat, acks_seen, lat, done_lat, d_node, d_plane;
  bit exp_hit, tracking, done_seen;
  int n_cmp = 0, n_err = 0;
  int ncnt = 0, pcnt = 0;

  always #5 clk = ~clk;

  raycast_core_trav #(.dw(32), .max_lvl(MAX), .lw(3)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .start_i(start_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .hit_o(hit_o), .lvl_o(lvl_o),
    .is_first_o(is_first_o), .idx_o(idx_o), .idx_next_i(idx_next_i),
    .is_exit_i(is_exit_i), .node_req_o(node_req_o), .node_ack_i(node_ack_i),
    .node_valid_i(node_valid_i), .node_leaf_i(node_leaf_i),
    .plane_req_o(plane_req_o), .plane_ack_i(plane_ack_i),
    .step_cnt_o(step_cnt_o), .state_o(state_o)
  );

  assign idx_next_i = is_first_o ? first_tab[lvl_o] : nxt_tab[idx_o];
  assign is_exit_i  = !is_first_o && ext_tab[idx_o];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event occurred, required none", name);
  endtask

  // memory / plane responders: ack in request cycle d (0 = same cycle)
  always begin
    @(posedge clk);
    #1;
    if (node_req_o) begin
      if (ncnt == d_node) begin
        node_ack_i = 1; node_valid_i = vtab[lvl_o][idx_o]; node_leaf_i = ltab[lvl_o][idx_o];
        ncnt = 0;
      end else begin
        node_ack_i = 0; ncnt++;
      end
    end else begin
      node_ack_i = 0; ncnt = 0;
    end
    if (plane_req_o) begin
      if (pcnt == d_plane) begin plane_ack_i = 1; pcnt = 0; end
      else begin plane_ack_i = 0; pcnt++; end
    end else begin
      plane_ack_i = 0; pcnt = 0;
    end
  end

  // Algorithmic traversal: fetch order, plane order, result and done latency.
  task automatic build_model(input int dn, input int dp);
    int lv;
    logic [2:0] stk [MAX];
    int tl;
    bit fin, moved;
    fetch_q.delete();
    plane_q.delete();
    lv = 0; stk[0] = first_tab[0]; tl = 1; exp_cnt = 0; exp_hit = 0; fin = 0;
    while (!fin) begin
      fetch_q.push_back({3'(lv), stk[lv]});
      exp_cnt++;
      tl += 1 + dn;
      if (vtab[lv][stk[lv]] && (ltab[lv][stk[lv]] || lv == MAX - 1)) begin
        exp_hit = 1; fin = 1;
      end else if (vtab[lv][stk[lv]]) begin
        lv++; stk[lv] = first_tab[lv]; tl += 1;
      end else begin
        moved = 0;
        while (!moved && !fin) begin
          plane_q.push_back({3'(lv), stk[lv]});
          tl += (1 + dp) + 1;
          if (!ext_tab[stk[lv]]) begin stk[lv] = nxt_tab[stk[lv]]; moved = 1; end
          else if (lv > 0) lv--;
          else begin exp_hit = 0; fin = 1; end
        end
      end
    end
    exp_lat = tl + 1;
  endtask

  // per-cycle comparison against the model while a ray is tracked
  always @(negedge clk) begin
    if (rst_n_i && tracking) begin
      lat++;
      check("busy", busy_o, 1);
      check("step_cnt_run", step_cnt_o, acks_seen);
      if (node_req_o) begin
        if (fetch_q.size() == 0) fail("fetch_extra");
        else begin
          check("fetch_addr", {lvl_o, idx_o}, fetch_q[0]);
          if (node_ack_i) begin void'(fetch_q.pop_front()); acks_seen++; end
        end
      end
      if (plane_req_o) begin
        if (plane_q.size() == 0) fail("plane_extra");
        else begin
          check("plane_addr", {lvl_o, idx_o}, plane_q[0]);
          if (plane_ack_i) void'(plane_q.pop_front());
        end
      end
      if (done_o) begin
        check("hit", hit_o, exp_hit);
        check("step_cnt_done", step_cnt_o, exp_cnt);
        check("done_latency", lat, exp_lat);
        check("fetch_left", fetch_q.size(), 0);
        check("plane_left", plane_q.size(), 0);
        done_lat = lat;
        done_seen = 1;
        tracking = 0;
      end
    end else if (rst_n_i && done_o) begin
      fail("done_unexpected");
    end
  end

  task automatic clear_tabs();
    for (int l = 0; l < MAX; l++) begin
      first_tab[l] = '0;
      for (int i = 0; i < 8; i++) begin vtab[l][i] = 0; ltab[l][i] = 0; end
    end
    for (int i = 0; i < 8; i++) begin nxt_tab[i] = 3'(i); ext_tab[i] = 1; end
  endtask

  task automatic start_ray(input int dn, input int dp);
    d_node = dn; d_plane = dp;
    build_model(dn, dp);
    acks_seen = 0; done_seen = 0;
    @(posedge clk); #1 start_i = 1;
    @(posedge clk); #1 start_i = 0; lat = 0; tracking = 1;
  endtask

  task automatic run_ray(input string name, input int dn, input int dp, input bit stray,
                         input int lit_cnt, input bit lit_hit, input int lit_lat);
    start_ray(dn, dp);
    if (stray) begin
      repeat (3) @(posedge clk);
      #1 start_i = 1;
      @(posedge clk); #1 start_i = 0;
    end
    for (int i = 0; i < 2000 && !done_seen; i++) @(negedge clk);
    if (!done_seen) begin
      $display("FAIL %s_timeout: no done_o within 2000 cycles, required done", name);
      n_cmp++; n_err++; tracking = 0;
    end
    check({name, "_lit_cnt"}, step_cnt_o, lit_cnt);
    check({name, "_lit_hit"}, hit_o, lit_hit);
    check({name, "_lit_lat"}, done_lat, lit_lat);
    repeat (2) @(negedge clk);
    check({name, "_hit_held"}, hit_o, lit_hit);
    check({name, "_idle"}, busy_o, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_hit"}, hit_o, 0);
    check({tag, "_lvl"}, lvl_o, 0);
    check({tag, "_idx"}, idx_o, 0);
    check({tag, "_first"}, is_first_o, 0);
    check({tag, "_nreq"}, node_req_o, 0);
    check({tag, "_preq"}, plane_req_o, 0);
    check({tag, "_cnt"}, step_cnt_o, 0);
  endtask

  task automatic setup_root();
    clear_tabs();
    first_tab[0] = 3'd5; vtab[0][5] = 1; ltab[0][5] = 1;
  endtask

  task automatic setup_miss();
    clear_tabs();
    first_tab[0] = 3'd0;
    nxt_tab[0] = 3'd4; ext_tab[0] = 0;
    nxt_tab[4] = 3'd6; ext_tab[4] = 0;
    nxt_tab[6] = 3'd7; ext_tab[6] = 0;
  endtask

  task automatic setup_descent();
    clear_tabs();
    for (int l = 0; l < MAX; l++) begin first_tab[l] = 3'(l); vtab[l][l] = 1; end
  endtask

  task automatic setup_pop();
    clear_tabs();
    first_tab[0] = 3'd1; first_tab[1] = 3'd2; first_tab[2] = 3'd7;
    vtab[0][1] = 1; vtab[1][2] = 1;
    nxt_tab[2] = 3'd3; ext_tab[2] = 0;
    vtab[1][3] = 1; ltab[1][3] = 1;
  endtask

  initial begin
    rst_n_i = 0; start_i = 0; abort_i = 0;
    node_ack_i = 0; node_valid_i = 0; node_leaf_i = 0; plane_ack_i = 0;
    tracking = 0; done_seen = 0; d_node = 0; d_plane = 0; lat = 0; done_lat = 0;
    clear_tabs();
    #1 check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n_i = 1;

    setup_root();    run_ray("root_hit", 0, 0, 0, 1, 1, 3);
    setup_miss();    run_ray("root_miss", 0, 0, 0, 4, 0, 14);
    setup_descent(); run_ray("descent", 0, 0, 0, 8, 1, 17);
    setup_pop();     run_ray("pop_sibling", 0, 0, 0, 4, 1, 12);
    setup_pop();     run_ray("delayed", 5, 5, 1, 4, 1, 42);

    // abort while fetching at level 4
    setup_descent();
    start_ray(20, 0);
    for (int i = 0; i < 500 && !(node_req_o && lvl_o == 3'd4); i++) @(negedge clk);
    check("abort_reach_lvl4", {node_req_o, lvl_o}, {1'b1, 3'd4});
    tracking = 0;
    abort_i = 1;
    @(posedge clk); #1 abort_i = 0;
    check("abort_busy", busy_o, 0);
    check("abort_nreq", node_req_o, 0);
    check("abort_hit", hit_o, 0);
    for (int i = 0; i < 5; i++) begin @(negedge clk); check("abort_no_done", done_o, 0); end

    // reset asserted mid-PLANE
    setup_miss();
    start_ray(0, 10);
    for (int i = 0; i < 500 && !plane_req_o; i++) @(negedge clk);
    check("reset_reach_plane", plane_req_o, 1);
    tracking = 0;
    rst_n_i = 0;
    #1 check_all_zero("async_reset");
    repeat (2) @(negedge clk);
    rst_n_i = 1;

    // recovery, then abort in IDLE clears a held hit
    setup_root(); run_ray("recover", 0, 0, 0, 1, 1, 3);
    @(posedge clk); #1 abort_i = 1;
    @(posedge clk); #1 abort_i = 0;
    check("abort_idle_hit", hit_o, 0);
    check("abort_idle_busy", busy_o, 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
